// File: rtl/fifo_rd_stream_if.sv
// Consumer-facing valid/ready stream of the FIFO read-side output stage.
// A word transfers on any rising edge where m_valid and m_ready are both high.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: pops the FIFO memory into a
// 2-entry skid buffer and presents words on a valid/ready stream.
module fifo_rd_stream #(
    parameter int DSIZE = 8
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic               rempty,
    input  logic [DSIZE-1:0]   rdata,
    output logic               rinc,
    input  logic               rflush,
    fifo_rd_stream_if.master   m,
    output logic [15:0]        rdcount,
    output logic [1:0]         dbg_cnt
);
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t             cnt;
    logic [DSIZE-1:0] buf0;
    logic [DSIZE-1:0] buf1;
    logic             push;
    logic             pop;

    // Handshake: the consumer takes buf0 on an edge where m_valid && m_ready
    // and no flush is pending; m_valid/m_data are held while m_ready is low.
    // rinc depends only on registered occupancy and rempty, never on m_ready.
    assign rinc      = !rrst && !rempty && !rflush && (cnt != OCC_TWO);
    assign push      = rinc;
    assign pop       = m.m_valid && m.m_ready && !rflush;
    assign m.m_valid = (cnt != OCC_EMPTY);
    assign m.m_data  = buf0;
    assign dbg_cnt   = cnt;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt  <= OCC_EMPTY;
            buf0 <= '0;
            buf1 <= '0;
        end else if (rflush) begin
            cnt <= OCC_EMPTY;
        end else begin
            case (cnt)
                OCC_EMPTY: begin
                    if (push) begin
                        buf0 <= rdata;
                        cnt  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        buf0 <= rdata;
                    end else if (push) begin
                        buf1 <= rdata;
                        cnt  <= OCC_TWO;
                    end else if (pop) begin
                        cnt <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Push cannot happen here, so only the pop shifts.
                    if (pop) begin
                        buf0 <= buf1;
                        cnt  <= OCC_ONE;
                    end
                end
                default: cnt <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rdcount <= 16'd0;
        end else if (pop && (rdcount != 16'hFFFF)) begin
            rdcount <= rdcount + 16'd1;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a small FIFO model feeding rdata/rempty.
module tb_fifo_rd_stream;
  logic       rclk;
  logic       rrst;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       rflush;
  logic [15:0] rdcount;
  logic [1:0] dbg_cnt;

  fifo_rd_stream_if #(.DSIZE(8)) s_if ();

  fifo_rd_stream #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .rflush  (rflush),
    .m       (s_if.master),
    .rdcount (rdcount),
    .dbg_cnt (dbg_cnt)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         gap;
  int         rinc_pulses;
  logic       s_rinc;

  // clock / reset
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic do_reset();
    rrst = 1'b1;
    rflush = 1'b0;
    s_if.m_ready = 1'b0;
    @(posedge rclk); #1;
    @(posedge rclk); #1;
    rrst = 1'b0;
  endtask

  // One cycle: model FIFO drives rempty/rdata, sample pre-edge, clock, update model.
  task automatic tick();
    logic       s_pop;
    logic [7:0] s_data;
    rempty = gap || (fifo_q.size() == 0);
    rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #1;
    if (rempty) begin
      compared++;
      if (rinc !== 1'b0) begin
        mismatched++;
        $display("FAIL rinc_while_empty: got %b want 0", rinc);
      end
    end
    s_rinc = rinc;
    s_pop = s_if.m_valid && s_if.m_ready && !rflush;
    s_data = s_if.m_data;
    @(posedge rclk); #1;
    if (s_rinc) begin
      void'(fifo_q.pop_front());
      rinc_pulses++;
    end
    if (s_pop) got_q.push_back(s_data);
  endtask

  task automatic check_got(input string name);
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s_count: got %0d words want %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL %s_word%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    rflush = 1'b0;
    s_if.m_ready = 1'b1;
    rempty = 1'b0;
    rdata = 8'hFF;
    @(posedge rclk); #1;
    compared++;
    if ({s_if.m_valid, s_if.m_data, rdcount, rinc, dbg_cnt} !== 28'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%h rinc=%b cnt=%0d want all 0",
               s_if.m_valid, s_if.m_data, rdcount, rinc, dbg_cnt);
    end
    rempty = 1'b1;
    rrst = 1'b0;
    s_if.m_ready = 1'b0;
  endtask

  task automatic test_fill();
    fifo_q.delete(); got_q.delete(); gap = 0; rinc_pulses = 0;
    s_if.m_ready = 1'b1;
    tick();
    compared++;
    if (s_if.m_valid !== 1'b0) begin
      mismatched++; $display("FAIL fill_idle_valid: got %b want 0", s_if.m_valid);
    end
    fifo_q = '{8'h11, 8'h22, 8'h33};
    tick();
    compared++;
    if (s_rinc !== 1'b1) begin
      mismatched++; $display("FAIL fill_first_rinc: got %b want 1", s_rinc);
    end
    compared++;
    if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h11) begin
      mismatched++;
      $display("FAIL fill_latency: got v=%b d=%h want v=1 d=11", s_if.m_valid, s_if.m_data);
    end
    tick();
    compared++;
    if (s_if.m_data !== 8'h22) begin
      mismatched++; $display("FAIL fill_word2: got %h want 22", s_if.m_data);
    end
    tick();
    compared++;
    if (s_if.m_data !== 8'h33) begin
      mismatched++; $display("FAIL fill_word3: got %h want 33", s_if.m_data);
    end
    tick();
    compared++;
    if (s_if.m_valid !== 1'b0 || rdcount !== 16'd3 || rinc_pulses != 3) begin
      mismatched++;
      $display("FAIL fill_end: got v=%b rdcount=%0d pulses=%0d want v=0 rdcount=3 pulses=3",
               s_if.m_valid, rdcount, rinc_pulses);
    end
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_got("fill");
  endtask

  task automatic test_backpressure();
    got_q.delete(); rinc_pulses = 0;
    s_if.m_ready = 1'b0;
    fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'hA0) begin
        mismatched++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h want v=1 d=a0", i, s_if.m_valid, s_if.m_data);
      end
    end
    compared++;
    if (rinc_pulses != 2 || dbg_cnt !== 2'd2) begin
      mismatched++;
      $display("FAIL bp_absorb: got pulses=%0d cnt=%0d want 2 2", rinc_pulses, dbg_cnt);
    end
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    check_got("bp");
    compared++;
    if (rdcount !== 16'd8 || s_if.m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_end: got rdcount=%0d v=%b want 8 0", rdcount, s_if.m_valid);
    end
  endtask

  task automatic test_empty_gaps();
    got_q.delete();
    s_if.m_ready = 1'b1;
    fifo_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < 12; i++) begin
      gap = (i % 2 == 0);
      tick();
    end
    gap = 0;
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    check_got("gaps");
    compared++;
    if (rdcount !== 16'd12) begin
      mismatched++; $display("FAIL gaps_rdcount: got %0d want 12", rdcount);
    end
  endtask

  task automatic test_flush();
    got_q.delete();
    s_if.m_ready = 1'b0;
    fifo_q = '{8'h5A, 8'h5B, 8'h5C};
    tick(); tick();
    compared++;
    if (dbg_cnt !== 2'd2 || s_if.m_data !== 8'h5A) begin
      mismatched++;
      $display("FAIL flush_setup: got cnt=%0d d=%h want 2 5a", dbg_cnt, s_if.m_data);
    end
    rflush = 1'b1;
    s_if.m_ready = 1'b1;
    tick();
    rflush = 1'b0;
    compared++;
    if (s_rinc !== 1'b0) begin
      mismatched++; $display("FAIL flush_rinc: got %b want 0", s_rinc);
    end
    compared++;
    if (s_if.m_valid !== 1'b0 || rdcount !== 16'd12 || dbg_cnt !== 2'd0) begin
      mismatched++;
      $display("FAIL flush_after: got v=%b rdcount=%0d cnt=%0d want 0 12 0",
               s_if.m_valid, rdcount, dbg_cnt);
    end
    tick();
    compared++;
    if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h5C) begin
      mismatched++;
      $display("FAIL flush_resume: got v=%b d=%h want 1 5c", s_if.m_valid, s_if.m_data);
    end
    tick();
    exp_q = '{8'h5C};
    check_got("flush");
    compared++;
    if (rdcount !== 16'd13) begin
      mismatched++; $display("FAIL flush_rdcount: got %0d want 13", rdcount);
    end
  endtask

  task automatic test_saturation();
    fifo_q.delete();
    do_reset();
    rempty = 1'b0;
    rdata = 8'h77;
    s_if.m_ready = 1'b1;
    repeat (65535) @(posedge rclk);
    #1;
    compared++;
    if (rdcount !== 16'hFFFE) begin
      mismatched++; $display("FAIL sat_preload: got %h want fffe", rdcount);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge rclk); #1;
      compared++;
      if (rdcount !== 16'hFFFF || s_if.m_data !== 8'h77) begin
        mismatched++;
        $display("FAIL sat_hold_%0d: got c=%h d=%h want ffff 77", i, rdcount, s_if.m_data);
      end
    end
    rempty = 1'b1;
    s_if.m_ready = 1'b0;
    @(posedge rclk); #1;
    @(posedge rclk); #1;
  endtask

  task automatic test_async_reset();
    got_q.delete(); gap = 0;
    s_if.m_ready = 1'b0;
    fifo_q = '{8'hE0, 8'hE1, 8'hE2};
    tick(); tick();
    rempty = 1'b0;
    rdata = fifo_q[0];
    #2;
    compared++;
    if (dbg_cnt !== 2'd2 || rdcount !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL areset_setup: got cnt=%0d c=%h want 2 ffff", dbg_cnt, rdcount);
    end
    rrst = 1'b1;
    #1;
    compared++;
    if (s_if.m_valid !== 1'b0 || rinc !== 1'b0 || rdcount !== 16'd0 ||
        s_if.m_data !== 8'h00 || dbg_cnt !== 2'd0) begin
      mismatched++;
      $display("FAIL areset_immediate: got v=%b rinc=%b c=%h d=%h cnt=%0d want all 0",
               s_if.m_valid, rinc, rdcount, s_if.m_data, dbg_cnt);
    end
    @(posedge rclk); #1;
    rrst = 1'b0;
  endtask

  initial begin
    gap = 0;
    rinc_pulses = 0;
    s_rinc = 1'b0;
    test_reset();
    test_fill();
    test_backpressure();
    test_empty_gaps();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
